shift_reg_sequencer: RTL and testbench

Controller that sequences an external `universal_shift_register` through one full-duplex serial transfer. On `start`, it:
- parallel-loads a word,
- shifts it out MSB-first or LSB-first at a programmable bit rate, capturing `ser_in` into the vacated bit on every shift,
- presents the received word with a one-cycle `done` pulse.

It sits between a host (parallel side) and the shift register (`sr_ctrl`, `sr_d`, `sr_q`), and owns every `ctrl` decision for that register.

---
 rtl/shift_reg_sequencer.sv | 121 ++++++++++++
 tb/tb_shift_reg_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// Sequences an external universal shift register through one full-duplex serial
// transfer: parallel load, N shifts at a programmable bit rate, then present the received word.
module shift_reg_sequencer #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic [N-1:0] tx_data,
    input  logic         ser_in,
    output logic         ser_out,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rx_data,
    output logic [1:0]   sr_ctrl,
    output logic [N-1:0] sr_d,
    input  logic [N-1:0] sr_q
);

    localparam int BW = $clog2(N + 1);
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          dir_r;
    logic [N-1:0]  tx_r;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] bit_cnt;
    logic          shift_tick;

    assign shift_tick = (state == SHIFT) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
            rx_data <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                LOAD: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    if (shift_tick) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    rx_data <= sr_q;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Transfer parameters are captured only on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            dir_r <= dir;
            tx_r  <= tx_data;
        end
    end

    always_comb begin
        state_next = state;
        sr_ctrl    = 2'b00;
        sr_d       = '0;
        ser_out    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                sr_ctrl    = 2'b11;
                sr_d       = tx_r;
                state_next = SHIFT;
            end
            SHIFT: begin
                ser_out = dir_r ? sr_q[0] : sr_q[N-1];
                if (shift_tick) begin
                    // The received bit enters the end vacated by the shift.
                    if (dir_r) begin
                        sr_ctrl    = 2'b10;
                        sr_d[N-1]  = ser_in;
                    end else begin
                        sr_ctrl    = 2'b01;
                        sr_d[0]    = ser_in;
                    end
                    if (bit_cnt == BIT_LAST) state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: behavioural shift registers, a stream-level reference
// model feeding a scoreboard, and a monitor that checks each done pulse against it.
module tb_shift_reg_sequencer;

    localparam int N = 8;
    localparam int C = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, dir, ser_in, ser_in_drv, loop_en;
    logic [N-1:0] tx_data, rx_data, sr_d, sr_q;
    logic         ser_out, busy, done;
    logic [1:0]   sr_ctrl;

    logic         start_b;
    logic [N-1:0] tx_data_b, rx_data_b, sr_d_b, sr_q_b;
    logic         ser_out_b, busy_b, done_b;
    logic [1:0]   sr_ctrl_b;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [N-1:0] rx;
        int           cyc;
    } exp_t;
    exp_t sb_q[$];

    assign ser_in = loop_en ? ser_out : ser_in_drv;

    shift_reg_sequencer #(.N(N), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .tx_data(tx_data),
        .ser_in(ser_in), .ser_out(ser_out), .busy(busy), .done(done),
        .rx_data(rx_data), .sr_ctrl(sr_ctrl), .sr_d(sr_d), .sr_q(sr_q)
    );

    shift_reg_sequencer #(.N(N), .CLKS_PER_BIT(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .dir(1'b0), .tx_data(tx_data_b),
        .ser_in(ser_out_b), .ser_out(ser_out_b), .busy(busy_b), .done(done_b),
        .rx_data(rx_data_b), .sr_ctrl(sr_ctrl_b), .sr_d(sr_d_b), .sr_q(sr_q_b)
    );

    // Universal shift registers: serial-in comes from the end bit of d on a shift.
    always_ff @(posedge clk) begin
        if (reset) sr_q <= '0;
        else case (sr_ctrl)
            2'b01:   sr_q <= {sr_q[N-2:0], sr_d[0]};
            2'b10:   sr_q <= {sr_d[N-1], sr_q[N-1:1]};
            2'b11:   sr_q <= sr_d;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) sr_q_b <= '0;
        else case (sr_ctrl_b)
            2'b01:   sr_q_b <= {sr_q_b[N-2:0], sr_d_b[0]};
            2'b10:   sr_q_b <= {sr_d_b[N-1], sr_q_b[N-1:1]};
            2'b11:   sr_q_b <= sr_d_b;
            default: ;
        endcase
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bit k of the serial stream, in the order it is transmitted.
    function automatic logic [N-1:0] tx_stream(input logic d, input logic [N-1:0] w);
        logic [N-1:0] s;
        for (int k = 0; k < N; k++) s[k] = d ? w[k] : w[N-1-k];
        return s;
    endfunction

    // Received word: first bit ends at the far end of the register from where it entered.
    function automatic logic [N-1:0] model_rx(input logic d, input logic [N-1:0] s);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) begin
            if (d) r[k] = s[k];
            else   r[N-1-k] = s[k];
        end
        return r;
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done) begin
            check("done_pulse_width", {31'd0, prev_done}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_done: done=1 with no transfer pending (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("rx_data", rx_data, e.rx);
                check("done_cycle", cyc, e.cyc);
            end
        end
        if (busy === 1'b0) begin
            check("idle_ctrl", sr_ctrl, 2'b00);
            check("idle_d", sr_d, '0);
            check("idle_ser_out", ser_out, 1'b0);
        end
        prev_done = done;
    end

    task automatic run_xfer(input logic d, input logic [N-1:0] tx, input bit lp,
                            input logic [N-1:0] pat_in, input bit poke);
        logic [N-1:0] pat;
        logic [N-1:0] sd;
        exp_t         e;
        int           t0;
        bit           ok;
        pat     = lp ? tx_stream(d, tx) : pat_in;
        loop_en = lp;
        start   = 1'b1;
        dir     = d;
        tx_data = tx;
        ok      = 1'b0;
        for (int w = 0; w < 6 && !ok; w++) begin
            @(negedge clk);
            if (busy === 1'b1) ok = 1'b1;
        end
        start   = 1'b0;
        dir     = 1'($urandom);
        tx_data = N'($urandom);
        check("accept", {31'd0, ok}, 32'd1);
        if (!ok) return;
        t0    = cyc;
        e.rx  = model_rx(d, pat);
        e.cyc = t0 + 2 + N * C;
        sb_q.push_back(e);
        check("load_ctrl", sr_ctrl, 2'b11);
        check("load_d", sr_d, tx);
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < C; j++) begin
                @(negedge clk);
                if (poke && (k * C + j == 8)) begin
                    start   = 1'b1;
                    tx_data = N'($urandom);
                end else begin
                    start = 1'b0;
                end
                ser_in_drv = (j == C - 1) ? pat[k] : 1'($urandom);
                #1;
                check("ser_out", ser_out, d ? tx[k] : tx[N-1-k]);
                check("busy_shift", busy, 1'b1);
                sd = '0;
                if (j == C - 1) begin
                    if (d) sd[N-1] = pat[k];
                    else   sd[0]   = pat[k];
                end
                check("shift_ctrl", sr_ctrl, (j == C - 1) ? (d ? 2'b10 : 2'b01) : 2'b00);
                check("shift_d", sr_d, sd);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("done_state_busy", busy, 1'b1);
        check("done_state_ctrl", sr_ctrl, 2'b00);
        check("done_state_ser_out", ser_out, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int shifts;
        int done_at;
        bit got;
        reset = 1'b1; start = 1'b0; dir = 1'b0; tx_data = '0;
        ser_in_drv = 1'b0; loop_en = 1'b0; start_b = 1'b0; tx_data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rx", rx_data, '0);
        check("rst_ctrl", sr_ctrl, 2'b00);
        check("rst_d", sr_d, '0);
        check("rst_ser_out", ser_out, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        run_xfer(1'b0, 8'hA5, 1'b1, '0, 1'b0);
        repeat (2) @(negedge clk);
        run_xfer(1'b1, 8'h3C, 1'b0, 8'hFF, 1'b0);
        repeat (2) @(negedge clk);

        // Reset in cycle 12 of a transfer aborts it and clears the received word.
        loop_en = 1'b1;
        start   = 1'b1; dir = 1'b0; tx_data = 8'h96;
        got = 1'b0;
        for (int w = 0; w < 6 && !got; w++) begin
            @(negedge clk);
            if (busy === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        check("rst_accept", {31'd0, got}, 32'd1);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ctrl", sr_ctrl, 2'b00);
        check("midrst_rx", rx_data, '0);
        check("midrst_done", done, 1'b0);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        // Mid-transfer start is ignored; the next transfer follows back to back.
        run_xfer(1'b0, 8'h5A, 1'b1, '0, 1'b1);
        run_xfer(1'b1, 8'hC3, 1'b1, '0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_xfer(1'($urandom), N'($urandom), 1'($urandom), N'($urandom), (i % 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);

        // One clock per bit: every SHIFT cycle shifts, done in cycle 11.
        tx_data_b = 8'h81;
        start_b   = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        shifts  = 0;
        done_at = 0;
        for (int n = 1; n <= 20 && done_at == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (sr_ctrl_b == 2'b01) shifts++;
            if (done_b === 1'b1) done_at = n;
        end
        check("fast_done_cycle", done_at, 32'd11);
        check("fast_shift_count", shifts, 32'd8);
        check("fast_rx", rx_data_b, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
